// File: rtl/nessoc_vga_pkg.sv
// Shared VGA timing constants and pixel types for the NES video output path.
package nessoc_vga_pkg;

   // 640x480@60 horizontal timing, in VGA pixels
   localparam logic [9:0] H_ACTIVE = 10'd640;
   localparam logic [9:0] H_FP     = 10'd16;
   localparam logic [9:0] H_SYNC   = 10'd96;
   localparam logic [9:0] H_BP     = 10'd48;
   localparam logic [9:0] H_TOTAL  = 10'd800;

   // 640x480@60 vertical timing, in lines
   localparam logic [9:0] V_ACTIVE = 10'd480;
   localparam logic [9:0] V_FP     = 10'd10;
   localparam logic [9:0] V_SYNC   = 10'd2;
   localparam logic [9:0] V_BP     = 10'd33;
   localparam logic [9:0] V_TOTAL  = 10'd525;

   // PPU picture geometry and its 2x scaled width on the VGA raster
   localparam int         SRC_W    = 256;
   localparam int         SRC_H    = 240;
   localparam logic [9:0] PIC_W    = 10'd512;

   // Last odd display line that hands over a new source line (2*SRC_H-3)
   localparam logic [9:0] V_LAST_SWAP = 10'd477;

   typedef logic [5:0] nes_idx_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb24_t;

   // A buffered line is retired after its second display line (odd vcnt),
   // and the first line of a frame is loaded at the end of the last line.
   function automatic logic is_swap_line(input logic [9:0] v);
      return (v[0] && (v <= V_LAST_SWAP)) || (v == V_TOTAL - 10'd1);
   endfunction

endpackage

// File: rtl/nes_palette_rom.sv
// 64-entry NES 2C02 palette index to 24-bit RGB lookup, registered on enable.
import nessoc_vga_pkg::*;

module nes_palette_rom (
   input  logic     clk,
   input  logic     en,
   input  nes_idx_t idx,
   output rgb24_t   rgb
);

   function automatic logic [23:0] pal(input nes_idx_t i);
      logic [23:0] c;
      c = 24'h000000;
      case (i)
         6'h00: c = 24'h7C7C7C; 6'h01: c = 24'h0000FC; 6'h02: c = 24'h0000BC; 6'h03: c = 24'h4428BC;
         6'h04: c = 24'h940084; 6'h05: c = 24'hA80020; 6'h06: c = 24'hA81000; 6'h07: c = 24'h881400;
         6'h08: c = 24'h503000; 6'h09: c = 24'h007800; 6'h0A: c = 24'h006800; 6'h0B: c = 24'h005800;
         6'h0C: c = 24'h004058; 6'h0D: c = 24'h000000; 6'h0E: c = 24'h000000; 6'h0F: c = 24'h000000;
         6'h10: c = 24'hBCBCBC; 6'h11: c = 24'h0078F8; 6'h12: c = 24'h0058F8; 6'h13: c = 24'h6844FC;
         6'h14: c = 24'hD800CC; 6'h15: c = 24'hE40058; 6'h16: c = 24'hF83800; 6'h17: c = 24'hE45C10;
         6'h18: c = 24'hAC7C00; 6'h19: c = 24'h00B800; 6'h1A: c = 24'h00A800; 6'h1B: c = 24'h00A844;
         6'h1C: c = 24'h008888; 6'h1D: c = 24'h000000; 6'h1E: c = 24'h000000; 6'h1F: c = 24'h000000;
         6'h20: c = 24'hF8F8F8; 6'h21: c = 24'h3CBCFC; 6'h22: c = 24'h6888FC; 6'h23: c = 24'h9878F8;
         6'h24: c = 24'hF878F8; 6'h25: c = 24'hF85898; 6'h26: c = 24'hF87858; 6'h27: c = 24'hFCA044;
         6'h28: c = 24'hF8B800; 6'h29: c = 24'hB8F818; 6'h2A: c = 24'h58D854; 6'h2B: c = 24'h58F898;
         6'h2C: c = 24'h00E8D8; 6'h2D: c = 24'h787878; 6'h2E: c = 24'h000000; 6'h2F: c = 24'h000000;
         6'h30: c = 24'hFCFCFC; 6'h31: c = 24'hA4E4FC; 6'h32: c = 24'hB8B8F8; 6'h33: c = 24'hD8B8F8;
         6'h34: c = 24'hF8B8F8; 6'h35: c = 24'hF8A4C0; 6'h36: c = 24'hF0D0B0; 6'h37: c = 24'hFCE0A8;
         6'h38: c = 24'hF8D878; 6'h39: c = 24'hD8F878; 6'h3A: c = 24'hB8F8B8; 6'h3B: c = 24'hB8F8D8;
         6'h3C: c = 24'h00FCFC; 6'h3D: c = 24'hF8D8F8; 6'h3E: c = 24'h000000; 6'h3F: c = 24'h000000;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

   // Synchronous ROM read; holds its value while the pipeline is stalled
   always_ff @(posedge clk) begin
      if (en) rgb <= rgb24_t'(pal(idx));
   end

endmodule

// File: rtl/ppu_vga_sink.sv
// PPU pixel stream sink: ping-pong line buffers, 2x scaled 256x240 picture
// centred in a 640x480@60 raster, palette lookup and aligned VGA syncs.
import nessoc_vga_pkg::*;

module ppu_vga_sink #(
   parameter int CLK_DIV  = 2,
   parameter int H_BORDER = 64
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] VGA_STREAM_DATA,
   input  logic       VGA_STREAM_READY,
   input  logic       VGA_STREAM_SOF,
   output logic       VGA_STREAM_ACCEPT,
   output logic       VGA_HSYNC,
   output logic       VGA_VSYNC,
   output logic       VGA_BLANK_N,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       FRAME_START,
   output logic       UNDERRUN
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [9:0] HB      = 10'(H_BORDER);
   localparam logic [9:0] HS_BEG  = H_ACTIVE + H_FP;
   localparam logic [9:0] HS_END  = H_ACTIVE + H_FP + H_SYNC;
   localparam logic [9:0] VS_BEG  = V_ACTIVE + V_FP;
   localparam logic [9:0] VS_END  = V_ACTIVE + V_FP + V_SYNC;

   // ---------------- timing ----------------
   logic [DIV_W-1:0] div;
   logic             pe;
   logic [9:0]       hcnt, vcnt;
   logic             rst_q;

   assign pe = (div == DIV_W'(CLK_DIV - 1));

   // Pixel-enable divider
   always_ff @(posedge CLK) begin
      if (!RST)    div <= '0;
      else if (pe) div <= '0;
      else         div <= div + 1'b1;
   end

   // Raster counters, advance once per VGA pixel
   always_ff @(posedge CLK) begin
      if (!RST) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (pe) begin
         if (hcnt == H_TOTAL - 10'd1) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_TOTAL - 10'd1) ? 10'd0 : vcnt + 10'd1;
         end else begin
            hcnt <= hcnt + 10'd1;
         end
      end
   end

   // Delayed reset keeps ACCEPT low for the first cycle out of reset
   always_ff @(posedge CLK) begin
      rst_q <= RST;
   end

   // Frame marker, one CLK wide after the first pixel-enable of a frame
   always_ff @(posedge CLK) begin
      if (!RST) FRAME_START <= 1'b0;
      else      FRAME_START <= pe && (hcnt == 10'd0) && (vcnt == 10'd0);
   end

   // ---------------- write side ----------------
   logic       rd_sel;
   logic       wr_full;
   logic [7:0] wr_ptr;
   logic [7:0] wr_addr;
   logic       xfer;
   logic       swap;

   assign VGA_STREAM_ACCEPT = rst_q & ~wr_full;
   assign xfer    = VGA_STREAM_READY & VGA_STREAM_ACCEPT;
   // SOF resynchronises the writer to the start of the line
   assign wr_addr = VGA_STREAM_SOF ? 8'd0 : wr_ptr;
   assign swap    = pe && (hcnt == H_TOTAL - 10'd1) && is_swap_line(vcnt);

   // Writer pointer, fill state, buffer ownership and underrun flag.
   // A toggling swap only happens with wr_full=1, when no transfer can occur;
   // a failed (underrun) swap leaves the writer running undisturbed.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         wr_ptr   <= '0;
         wr_full  <= 1'b0;
         rd_sel   <= 1'b0;
         UNDERRUN <= 1'b0;
      end else begin
         if (swap) begin
            if (wr_full) begin
               rd_sel  <= ~rd_sel;
               wr_full <= 1'b0;
            end else begin
               UNDERRUN <= 1'b1;
            end
         end
         if (xfer) begin
            wr_ptr <= wr_addr + 8'd1;
            if (wr_addr == 8'd255) wr_full <= 1'b1;
         end
      end
   end

   // ---------------- line buffers ----------------
   logic [5:0] lb0 [0:SRC_W-1];
   logic [5:0] lb1 [0:SRC_W-1];
   logic [5:0] lb0_q, lb1_q;
   logic [7:0] rd_addr;

   assign rd_addr = 8'((hcnt - HB) >> 1);

   // LB0: written while the reader owns LB1
   always_ff @(posedge CLK) begin
      if (xfer && rd_sel) lb0[wr_addr] <= VGA_STREAM_DATA;
      if (pe)             lb0_q <= lb0[rd_addr];
   end

   // LB1: written while the reader owns LB0
   always_ff @(posedge CLK) begin
      if (xfer && !rd_sel) lb1[wr_addr] <= VGA_STREAM_DATA;
      if (pe)              lb1_q <= lb1[rd_addr];
   end

   // ---------------- display pipeline ----------------
   logic   in_pic0, hs0, vs0, bl0;
   logic   in_pic1, hs1, vs1, bl1, sel1;
   logic   in_pic2, hs2, vs2, bl2;
   rgb24_t pix;

   assign in_pic0 = (hcnt >= HB) && (hcnt < HB + PIC_W) && (vcnt < V_ACTIVE);
   assign hs0     = ~((hcnt >= HS_BEG) && (hcnt < HS_END));
   assign vs0     = ~((vcnt >= VS_BEG) && (vcnt < VS_END));
   assign bl0     = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE);

   // S1: capture flags alongside the line-buffer read
   always_ff @(posedge CLK) begin
      if (!RST) begin
         in_pic1 <= 1'b0;
         hs1     <= 1'b1;
         vs1     <= 1'b1;
         bl1     <= 1'b0;
         sel1    <= 1'b0;
      end else if (pe) begin
         in_pic1 <= in_pic0;
         hs1     <= hs0;
         vs1     <= vs0;
         bl1     <= bl0;
         sel1    <= rd_sel;
      end
   end

   nes_palette_rom u_pal (
      .clk (CLK),
      .en  (pe),
      .idx (sel1 ? lb1_q : lb0_q),
      .rgb (pix)
   );

   // S2: flags aligned with the palette output register
   always_ff @(posedge CLK) begin
      if (!RST) begin
         in_pic2 <= 1'b0;
         hs2     <= 1'b1;
         vs2     <= 1'b1;
         bl2     <= 1'b0;
      end else if (pe) begin
         in_pic2 <= in_pic1;
         hs2     <= hs1;
         vs2     <= vs1;
         bl2     <= bl1;
      end
   end

   assign VGA_HSYNC   = hs2;
   assign VGA_VSYNC   = vs2;
   assign VGA_BLANK_N = bl2;
   assign VGA_R       = in_pic2 ? pix.r : 8'd0;
   assign VGA_G       = in_pic2 ? pix.g : 8'd0;
   assign VGA_B       = in_pic2 ? pix.b : 8'd0;

endmodule
